// File: rtl/tri_capture_if.sv
// Capture controller port bundle: sample/trigger/control inputs plus BRAM write port and frame status.
// master drives the stimulus side (trigger stage, display reader); slave is the capture controller.
interface tri_capture_if #(
   parameter int ADDR_W = 10
);
   logic              sample_en;
   logic [7:0]        data_in;
   logic              tri_valid;
   logic              arm;
   logic              frame_ack;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              frame_ready;
   logic [ADDR_W-1:0] frame_start;
   logic              busy;
   logic              auto_trig;

   modport master (
      output sample_en, data_in, tri_valid, arm, frame_ack,
      input  wr_en, wr_addr, wr_data, frame_ready, frame_start, busy, auto_trig
   );

   modport slave (
      input  sample_en, data_in, tri_valid, arm, frame_ack,
      output wr_en, wr_addr, wr_data, frame_ready, frame_start, busy, auto_trig
   );
endinterface

// File: rtl/tri_capture.sv
// Pre/post-trigger frame capture into a circular BRAM; AUTO_TRIG_EN adds a forced trigger after AUTO_TIMEOUT cycles.
// Write port registered (1 cycle after sample_en); a held frame blocks all writes until frame_ack.
module tri_capture #(
   parameter int ADDR_W       = 10,
   parameter int PRE_DEPTH    = 512,
   parameter int AUTO_TIMEOUT = 1000000
) (
   input logic          clk_i,
   input logic          rst_n_i,
   tri_capture_if.slave cap
);
   localparam int DEPTH      = 1 << ADDR_W;
   localparam int POST_DEPTH = DEPTH - PRE_DEPTH;

   localparam logic [ADDR_W:0]   PRE_CNT  = (ADDR_W+1)'(PRE_DEPTH);
   localparam logic [ADDR_W:0]   POST_CNT = (ADDR_W+1)'(POST_DEPTH);
   localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      WAIT_TRIG,
      POST,
      READY
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
   logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
   logic [ADDR_W:0]   post_first;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              frame_ready_q;
   logic [ADDR_W-1:0] frame_start_q;
   logic              busy_q;
   logic              accept;
   logic              trig_fire;
   logic              trig_force;

`ifdef AUTO_TRIG_EN
   localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            auto_trig_q;

   assign trig_force    = (state_q == WAIT_TRIG) && (to_cnt_q == TO_LAST);
   assign cap.auto_trig = auto_trig_q;
`else
   assign trig_force    = 1'b0;
   assign cap.auto_trig = 1'b0;
`endif

   always_comb begin
      accept     = cap.sample_en &&
                   (state_q == PREFILL || state_q == WAIT_TRIG || state_q == POST);
      ptr_d      = ptr_q + ADDR_W'(1);
      pre_cnt_d  = pre_cnt_q + (ADDR_W+1)'(1);
      post_cnt_d = post_cnt_q + (ADDR_W+1)'(1);
      // A sample accepted in the trigger cycle is the trigger sample and the first post sample
      post_first = accept ? (ADDR_W+1)'(1) : '0;
      trig_fire  = (state_q == WAIT_TRIG) && (cap.tri_valid || trig_force);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         pre_cnt_q     <= '0;
         post_cnt_q    <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_ready_q <= 1'b0;
         frame_start_q <= '0;
         busy_q        <= 1'b0;
`ifdef AUTO_TRIG_EN
         to_cnt_q      <= '0;
         auto_trig_q   <= 1'b0;
`endif
      end else begin
         wr_en_q <= accept;
         if (accept) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= cap.data_in;
            ptr_q     <= ptr_d;
         end

         case (state_q)
            IDLE: begin
               if (cap.arm) begin
                  state_q   <= PREFILL;
                  pre_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end

            PREFILL: begin
               if (accept) begin
                  pre_cnt_q <= pre_cnt_d;
                  if (pre_cnt_d == PRE_CNT) begin
                     state_q  <= WAIT_TRIG;
`ifdef AUTO_TRIG_EN
                     to_cnt_q <= '0;
`endif
                  end
               end
            end

            WAIT_TRIG: begin
`ifdef AUTO_TRIG_EN
               to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
               if (trig_fire) begin
                  frame_start_q <= ptr_q - PRE_OFS;
                  post_cnt_q    <= post_first;
`ifdef AUTO_TRIG_EN
                  auto_trig_q   <= ~cap.tri_valid;
`endif
                  if (post_first == POST_CNT) begin
                     state_q <= READY;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= POST;
                  end
               end
            end

            POST: begin
               if (accept) begin
                  post_cnt_q <= post_cnt_d;
                  if (post_cnt_d == POST_CNT) begin
                     state_q <= READY;
                     busy_q  <= 1'b0;
                  end
               end
            end

            READY: begin
               // frame_ready rises one cycle after the last write has reached the BRAM port
               if (frame_ready_q && cap.frame_ack) begin
                  state_q       <= IDLE;
                  frame_ready_q <= 1'b0;
`ifdef AUTO_TRIG_EN
                  auto_trig_q   <= 1'b0;
`endif
               end else begin
                  frame_ready_q <= 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign cap.wr_en       = wr_en_q;
   assign cap.wr_addr     = wr_addr_q;
   assign cap.wr_data     = wr_data_q;
   assign cap.frame_ready = frame_ready_q;
   assign cap.frame_start = frame_start_q;
   assign cap.busy        = busy_q;

endmodule
